alu_operand_stage: RTL
======================

// Module: alu_operand_stage
// PURPOSE
//  Decode/operand-fetch stage directly upstream of alu_top. Accepts a 32-bit instruction, decodes opcode/funct to instr_ID,
//  reads source registers from an internal register file (written back from downstream), builds rt (register or extended
//  immediate) and presents {ir, instr_ID, rs, rt, dest} in a pipeline register. Scoreboard stalls on RAW/WAW hazards.
// PARAMETERS
//  DATA_W  32  operand/register width
//  NREG    32  register count; address width fixed at 5 bits
//  BYPASS  1   1 = same-cycle writeback forwarded to operand read; 0 = no forwarding, stall until wb done
// PORTS
//  clk           in   1       rising-edge clock
//  reset         in   1       asynchronous, active-low (0 = reset)
//  in_valid      in   1       instruction offered
//  in_ready      out  1       stage can accept this cycle
//  in_ir         in   32      instruction word
//  out_valid     out  1       output register holds an instruction
//  out_ready     in   1       consumer takes output this cycle
//  out_ir        out  32      registered instruction word (to alu_top.ir)
//  out_instr_ID  out  32      decoded ID (to alu_top.instr_ID)
//  out_rs        out  DATA_W  operand 1
//  out_rt        out  DATA_W  operand 2 (register or immediate)
//  out_dest      out  5       destination register
//  out_illegal   out  1       undecodable instruction
//  wb_en         in   1       writeback strobe
//  wb_addr       in   5       writeback register
//  wb_data       in   DATA_W  writeback value
// BEHAVIOUR
//  Fields: op=ir[31:26], s=ir[25:21], t=ir[20:16], d=ir[15:11], shamt=ir[10:6], funct=ir[5:0], imm=ir[15:0].
//  R-type (op 0,3,4,19): rs=R[s], rt=R[t], dest=d. I-type (op 1,2,5,6,7,20): rs=R[s], dest=t.
//  ID map: op0 f0..3->1..4; op1->5; op2->6; op3 f0->7; op4 f0->8; op5->9; op6->10; op7 f0->11, f1->12;
//   op19 f0->24; op20->25. Anything else -> ID 0, out_illegal=1.
//  Immediates: op1,2,20 sign-extend imm; op5,6 zero-extend imm; op7 rt = zero-extended shamt (0..31).
//  Register r0 is an ordinary writable register (not hardwired zero).
//  Handshake: accept = in_valid & in_ready; in_ready = (~out_valid | out_ready) & ~hazard.
//   Output register loads on accept (latency 1); out_valid clears when out_ready & ~accept.
//   Output fields hold stable while out_valid & ~out_ready.
//  Scoreboard: busy[NREG]. On accept of legal instr, busy[dest] <= 1. On wb_en, R[wb_addr] <= wb_data, busy[wb_addr] <= 0.
//   Same-cycle set and clear of same register: set wins. Illegal instr sets nothing.
//  hazard = in_valid & legal & (busy[s] | (R-type & busy[t]) | busy[dest]) after applying this cycle's wb clear
//   when BYPASS=1 (wb to a busy source unblocks same cycle, wb_data forwarded); BYPASS=0: busy uses registered value.
//  Reset (async, any time incl. mid-stall): out_valid=0, in_ready=0 while asserted, all out_* = 0, all R[] = 0,
//   all busy = 0. In-flight instruction discarded. First cycle after release in_ready=1.
//  Arithmetic: no width change; extensions to DATA_W exactly as above.
// TESTING
//  1) reset low then high; in_ir=addi s=1,t=2,imm=0xFFFF -> next cycle out_instr_ID=5, out_rs=0, out_rt=0xFFFFFFFF, dest=2.
//  2) wb r3=7,r4=5; issue sub d=5,s=3,t=4 -> out_instr_ID=2, out_rs=7, out_rt=5; next add reading r5 stalls
//     (in_ready=0) until wb_en r5; with BYPASS=1 accepted in wb cycle with out_rs=wb_data.
//  3) op7 f1 shamt=4 -> ID 12, out_rt=4; op6 imm=0x8000 -> ID 10, out_rt=0x00008000; op20 imm=0x8000 -> rt=0xFFFF8000.
//  4) out_ready=0 for 3 cycles with in_valid=1 -> out_* stable, in_ready=0, no second accept; out_ready=1 -> back-to-back.
//  5) op=63 -> out_illegal=1, ID 0, busy unchanged; slt op19 f0 -> ID 24, dest=d.
//  6) assert reset while stalled with busy bits set -> out_valid=0, all busy cleared, R[*]=0 on release.

Source files
------------

// File: rtl/alu_operand_stage.sv
// Decode / operand-fetch stage feeding alu_top: decodes the instruction word,
// reads the register file, builds operand 2, and tracks pending writes.
//
// Ports:
//   clk, reset (async, active-low)
//   in_valid/in_ready/in_ir          : instruction input handshake
//   out_valid/out_ready              : output register handshake
//   out_ir/out_instr_ID/out_rs/out_rt/out_dest/out_illegal : decoded bundle
//   wb_en/wb_addr/wb_data            : register writeback from downstream
module alu_operand_stage #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_ir,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_ir,
    output logic [31:0]       out_instr_ID,
    output logic [DATA_W-1:0] out_rs,
    output logic [DATA_W-1:0] out_rt,
    output logic [4:0]        out_dest,
    output logic              out_illegal,
    input  logic              wb_en,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data
);

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  s, t, d, shamt;
    logic [15:0] imm;

    assign op    = in_ir[31:26];
    assign s     = in_ir[25:21];
    assign t     = in_ir[20:16];
    assign d     = in_ir[15:11];
    assign shamt = in_ir[10:6];
    assign funct = in_ir[5:0];
    assign imm   = in_ir[15:0];

    logic [DATA_W-1:0] rf_q [NREG];
    logic [DATA_W-1:0] rf_d [NREG];
    logic [NREG-1:0]   busy_q, busy_d;

    logic              valid_q, valid_d;
    logic [31:0]       ir_q, ir_d;
    logic [31:0]       id_q, id_d;
    logic [DATA_W-1:0] rs_q, rs_d;
    logic [DATA_W-1:0] rt_q, rt_d;
    logic [4:0]        dest_q, dest_d;
    logic              ill_q, ill_d;

    logic [31:0]       id;
    logic              is_r;
    logic              legal;
    logic [4:0]        dest;
    logic [DATA_W-1:0] rs_val, rt_reg, rt_val;
    logic [NREG-1:0]   wb_mask, busy_rd;
    logic              hazard, accept;

    // Opcode/funct to instruction ID; ID 0 marks an undecodable word.
    always_comb begin
        id   = 32'd0;
        is_r = 1'b0;
        unique case (op)
            6'd0: begin
                is_r = 1'b1;
                if (funct <= 6'd3) id = 32'(funct) + 32'd1;
            end
            6'd3: begin
                is_r = 1'b1;
                if (funct == 6'd0) id = 32'd7;
            end
            6'd4: begin
                is_r = 1'b1;
                if (funct == 6'd0) id = 32'd8;
            end
            6'd19: begin
                is_r = 1'b1;
                if (funct == 6'd0) id = 32'd24;
            end
            6'd1:  id = 32'd5;
            6'd2:  id = 32'd6;
            6'd5:  id = 32'd9;
            6'd6:  id = 32'd10;
            6'd20: id = 32'd25;
            6'd7: begin
                if (funct == 6'd0)      id = 32'd11;
                else if (funct == 6'd1) id = 32'd12;
            end
            default: id = 32'd0;
        endcase
    end

    assign legal = (id != 32'd0);
    assign dest  = is_r ? d : t;

    assign wb_mask = wb_en ? ({{(NREG-1){1'b0}}, 1'b1} << wb_addr)
                           : '0;

    // With forwarding, a writeback landing this cycle already counts as done.
    assign busy_rd = BYPASS ? (busy_q & ~wb_mask) : busy_q;

    assign rs_val = (BYPASS && wb_en && wb_addr == s) ? wb_data : rf_q[s];
    assign rt_reg = (BYPASS && wb_en && wb_addr == t) ? wb_data : rf_q[t];

    always_comb begin
        rt_val = '0;
        unique case (op)
            6'd0, 6'd3, 6'd4, 6'd19:
                rt_val = rt_reg;
            6'd1, 6'd2, 6'd20:
                rt_val = {{(DATA_W-16){imm[15]}}, imm};
            6'd5, 6'd6:
                rt_val = {{(DATA_W-16){1'b0}}, imm};
            6'd7:
                rt_val = {{(DATA_W-5){1'b0}}, shamt};
            default:
                rt_val = '0;
        endcase
    end

    assign hazard = in_valid & legal &
                    (busy_rd[s] | (is_r & busy_rd[t]) | busy_rd[dest]);

    assign in_ready = reset & (~valid_q | out_ready) & ~hazard;
    assign accept   = in_valid & in_ready;

    always_comb begin
        valid_d = valid_q;
        ir_d    = ir_q;
        id_d    = id_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        dest_d  = dest_q;
        ill_d   = ill_q;
        if (accept) begin
            valid_d = 1'b1;
            ir_d    = in_ir;
            id_d    = id;
            rs_d    = rs_val;
            rt_d    = rt_val;
            dest_d  = dest;
            ill_d   = ~legal;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Clear first so a same-cycle issue to the same register stays busy.
    always_comb begin
        busy_d = busy_q & ~wb_mask;
        if (accept && legal) busy_d[dest] = 1'b1;
    end

    always_comb begin
        rf_d = rf_q;
        if (wb_en) rf_d[wb_addr] = wb_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            ir_q    <= '0;
            id_q    <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            dest_q  <= '0;
            ill_q   <= 1'b0;
            busy_q  <= '0;
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else begin
            valid_q <= valid_d;
            ir_q    <= ir_d;
            id_q    <= id_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            dest_q  <= dest_d;
            ill_q   <= ill_d;
            busy_q  <= busy_d;
            rf_q    <= rf_d;
        end
    end

    assign out_valid    = valid_q;
    assign out_ir       = ir_q;
    assign out_instr_ID = id_q;
    assign out_rs       = rs_q;
    assign out_rt       = rt_q;
    assign out_dest     = dest_q;
    assign out_illegal  = ill_q;

endmodule
